// File: rtl/inst_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit_pkg
// Brief    : Shared types and constants for the instruction fetch stage.
// Revision : 1.0
// ============================================================================
package inst_fetch_unit_pkg;

   localparam int              XLEN             = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage : inst_fetch_unit_pkg
`default_nettype wire

// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit_if
// Brief    : Redirect, instruction-memory and core-side bundle of the fetch stage.
// Revision : 1.0
// ============================================================================
interface inst_fetch_unit_if;
   import inst_fetch_unit_pkg::*;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst_pc;
   logic [XLEN-1:0] inst;

   // master = fetch unit, slave = surrounding core/memory
   modport master (
      input  redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
      output imem_req, imem_addr, inst_valid, inst_pc, inst
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
      input  imem_req, imem_addr, inst_valid, inst_pc, inst
   );

endinterface : inst_fetch_unit_if
`default_nettype wire

// File: rtl/inst_fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit_fifo
// Brief    : DEPTH x {pc, inst} synchronous FIFO with flush and FWFT head.
// Revision : 1.0
// ============================================================================
module inst_fetch_unit_fifo
   import inst_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = AW + 1
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   input  wire logic         i_push,
   input  wire fetch_entry_t i_data,
   input  wire logic         i_pop,
   input  wire logic         i_flush,
   output      logic [CW-1:0] o_count,
   output      logic         o_valid,
   output      fetch_entry_t o_head
);

   fetch_entry_t  r_mem [DEPTH];
   fetch_entry_t  r_last;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_valid;
   logic          w_do_pop;
   logic [CW-1:0] w_count_nxt;

   assign w_valid  = (r_count != '0);
   assign w_do_pop = i_pop & w_valid;

   always_comb begin
      w_count_nxt = r_count + CW'(i_push) - CW'(w_do_pop);
   end

   // DEPTH is a power of two, so pointers wrap naturally
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && !i_flush && i_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Holds the most recently presented head so outputs stay put when empty
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last <= '0;
      end else if (w_valid) begin
         r_last <= r_mem[r_rd_ptr];
      end
   end

   assign o_count = r_count;
   assign o_valid = w_valid;
   assign o_head  = w_valid ? r_mem[r_rd_ptr] : r_last;

endmodule : inst_fetch_unit_fifo
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Brief    : Fetch PC owner, single-outstanding imem reader and prefetch queue.
// Revision : 1.0
// ============================================================================
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input wire logic           clk,
   input wire logic           rst_n,
   inst_fetch_unit_if.master  if_fetch
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_state_e    r_state;
   fetch_state_e    w_state_nxt;
   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] w_fetch_pc_nxt;
   logic [XLEN-1:0] r_imem_addr;
   logic [XLEN-1:0] w_imem_addr_nxt;

   logic            w_redirect;
   logic [XLEN-1:0] w_redirect_pc;
   logic            w_ack;
   logic            w_push;
   logic            w_pop;
   logic [XLEN-1:0] w_pc_inc;
   logic [CW-1:0]   w_count;
   logic [CW-1:0]   w_count_nxt;
   logic            w_space;
   logic            w_fifo_valid;
   fetch_entry_t    w_push_data;
   fetch_entry_t    w_head;

   assign w_redirect    = if_fetch.redirect_valid;
   assign w_redirect_pc = word_align(if_fetch.redirect_pc);
   assign w_ack         = if_fetch.imem_ack;
   assign w_pc_inc      = r_fetch_pc + 32'd4;

   assign w_push = (r_state == ST_WAIT) & w_ack & ~w_redirect;
   assign w_pop  = w_fifo_valid & if_fetch.inst_ready;

   // A request is only launched when its result is guaranteed a slot
   always_comb begin
      if (w_redirect) begin
         w_count_nxt = '0;
      end else begin
         w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);
      end
   end

   assign w_space = (w_count_nxt < CW'(DEPTH));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_fetch_pc  <= RESET_PC;
         r_imem_addr <= RESET_PC;
      end else begin
         r_state     <= w_state_nxt;
         r_fetch_pc  <= w_fetch_pc_nxt;
         r_imem_addr <= w_imem_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_fetch_pc_nxt  = r_fetch_pc;
      w_imem_addr_nxt = r_imem_addr;
      case (r_state)
         ST_IDLE: begin
            if (w_redirect) begin
               w_state_nxt     = ST_WAIT;
               w_fetch_pc_nxt  = w_redirect_pc;
               w_imem_addr_nxt = w_redirect_pc;
            end else if (w_space) begin
               w_state_nxt     = ST_WAIT;
               w_imem_addr_nxt = r_fetch_pc;
            end
         end
         ST_WAIT: begin
            if (w_ack && w_redirect) begin
               w_state_nxt     = ST_WAIT;
               w_fetch_pc_nxt  = w_redirect_pc;
               w_imem_addr_nxt = w_redirect_pc;
            end else if (w_ack) begin
               w_fetch_pc_nxt  = w_pc_inc;
               w_imem_addr_nxt = w_pc_inc;
               w_state_nxt     = w_space ? ST_WAIT : ST_IDLE;
            end else if (w_redirect) begin
               // Address must stay stable until the in-flight read completes
               w_state_nxt    = ST_DISCARD;
               w_fetch_pc_nxt = w_redirect_pc;
            end
         end
         ST_DISCARD: begin
            if (w_redirect) begin
               w_fetch_pc_nxt = w_redirect_pc;
            end
            if (w_ack) begin
               w_state_nxt     = ST_WAIT;
               w_imem_addr_nxt = w_redirect ? w_redirect_pc : r_fetch_pc;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_push_data.pc   = r_imem_addr;
   assign w_push_data.inst = if_fetch.imem_rdata;

   inst_fetch_unit_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .i_flush (w_redirect),
      .o_count (w_count),
      .o_valid (w_fifo_valid),
      .o_head  (w_head)
   );

   assign if_fetch.imem_req   = (r_state != ST_IDLE);
   assign if_fetch.imem_addr  = r_imem_addr;
   assign if_fetch.inst_valid = w_fifo_valid;
   assign if_fetch.inst_pc    = w_head.pc;
   assign if_fetch.inst       = w_head.inst;

endmodule : inst_fetch_unit
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_unit
// Brief    : Directed scoreboard bench for inst_fetch_unit with a latency-configurable imem.
// Revision : 1.0
// ============================================================================
module tb_inst_fetch_unit;
   import inst_fetch_unit_pkg::*;

   localparam logic [31:0] c_KEY = 32'h5A5A_0013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   inst_fetch_unit_if u_bus ();

   inst_fetch_unit #(
      .DEPTH    (4),
      .RESET_PC (32'h0)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_fetch (u_bus)
   );

   int          total = 0;
   int          bad   = 0;
   logic [63:0] exp_q [$];
   int          cyc = 0;
   int          pops = 0;
   int          first_pop = 0;
   int          last_pop = 0;
   logic [31:0] slow_addr = 32'h1;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ c_KEY;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic expect_pc(input logic [31:0] pc);
      exp_q.push_back({pc, mem_word(pc)});
   endtask

   // Instruction memory: zero-wait except a 3-cycle delay on slow_addr
   initial begin
      int waited;
      int lat;
      waited = 0;
      u_bus.imem_ack   = 1'b0;
      u_bus.imem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         u_bus.imem_ack = 1'b0;
         if (u_bus.imem_req) begin
            lat = (u_bus.imem_addr == slow_addr) ? 3 : 0;
            if (waited >= lat) begin
               u_bus.imem_ack   = 1'b1;
               u_bus.imem_rdata = mem_word(u_bus.imem_addr);
               waited = 0;
            end else begin
               waited++;
            end
         end else begin
            waited = 0;
         end
      end
   end

   // Monitor: every accepted head is checked against the scoreboard
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && u_bus.inst_valid && u_bus.inst_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL pop_unexpected: got pc=%h inst=%h want none", u_bus.inst_pc, u_bus.inst);
            end else begin
               e = exp_q.pop_front();
               if ({u_bus.inst_pc, u_bus.inst} !== e) begin
                  bad++;
                  $display("FAIL pop_data: got pc=%h inst=%h want pc=%h inst=%h",
                           u_bus.inst_pc, u_bus.inst, e[63:32], e[31:0]);
               end
            end
            if (pops == 0) first_pop = cyc;
            last_pop = cyc;
            pops++;
         end
      end
   end

   task automatic do_reset();
      u_bus.inst_ready     = 1'b0;
      u_bus.redirect_valid = 1'b0;
      u_bus.redirect_pc    = 32'h0;
      slow_addr = 32'h1;
      rst_n = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      pops = 0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_drain: got %0d left want 0", name, exp_q.size());
         exp_q.delete();
      end
      u_bus.inst_ready = 1'b0;
   endtask

   task automatic wait_addr(input string name, input logic [31:0] a, input bit eq);
      int n;
      n = 0;
      while (((u_bus.imem_req && u_bus.imem_addr == a) != eq) && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      if (n >= 30) begin
         bad++;
         $display("FAIL %s_timeout: got addr=%h want wait on %h", name, u_bus.imem_addr, a);
      end
   endtask

   initial begin
      // 1: reset values and first request
      do_reset();
      check("rst_req",   32'(u_bus.imem_req),   32'h0);
      check("rst_addr",  u_bus.imem_addr,       32'h0);
      check("rst_valid", 32'(u_bus.inst_valid), 32'h0);
      check("rst_pc",    u_bus.inst_pc,         32'h0);
      check("rst_inst",  u_bus.inst,            32'h0);
      @(posedge clk); #1;
      check("t1_req",   32'(u_bus.imem_req),   32'h1);
      check("t1_addr",  u_bus.imem_addr,       32'h0);
      check("t1_valid", 32'(u_bus.inst_valid), 32'h0);

      // 2: zero-wait streaming, one instruction per cycle
      do_reset();
      u_bus.inst_ready = 1'b1;
      for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
      drain("t2");
      check("t2_bubbles", 32'(last_pop - first_pop), 32'd7);

      // 3: back-pressure fills exactly DEPTH entries, then resumes at 0x10
      do_reset();
      repeat (8) begin @(posedge clk); #1; end
      check("t3_req_stop", 32'(u_bus.imem_req),   32'h0);
      check("t3_valid",    32'(u_bus.inst_valid), 32'h1);
      check("t3_head",     u_bus.inst_pc,         32'h0);
      for (int i = 0; i < 6; i++) expect_pc(32'(i * 4));
      u_bus.inst_ready = 1'b1;
      @(posedge clk); #1;
      check("t3_req_resume", 32'(u_bus.imem_req), 32'h1);
      check("t3_addr_resume", u_bus.imem_addr,    32'h10);
      drain("t3");

      // 4: redirect while a slow read is outstanding
      do_reset();
      slow_addr = 32'h8;
      u_bus.inst_ready = 1'b1;
      expect_pc(32'h0);
      expect_pc(32'h4);
      wait_addr("t4_req8", 32'h8, 1'b1);
      @(posedge clk); #1;
      u_bus.redirect_valid = 1'b1;
      u_bus.redirect_pc    = 32'h103;
      @(posedge clk); #1;
      u_bus.redirect_valid = 1'b0;
      check("t4_req_hold",  32'(u_bus.imem_req),   32'h1);
      check("t4_addr_hold", u_bus.imem_addr,       32'h8);
      check("t4_valid",     32'(u_bus.inst_valid), 32'h0);
      expect_pc(32'h100);
      expect_pc(32'h104);
      expect_pc(32'h108);
      wait_addr("t4_leave8", 32'h8, 1'b0);
      check("t4_addr_new", u_bus.imem_addr, 32'h100);
      drain("t4");

      // 5: redirect coincident with ack and pop, two entries queued
      do_reset();
      repeat (3) begin @(posedge clk); #1; end
      check("t5_addr_pre",  u_bus.imem_addr,       32'h8);
      check("t5_valid_pre", 32'(u_bus.inst_valid), 32'h1);
      check("t5_head_pre",  u_bus.inst_pc,         32'h0);
      expect_pc(32'h0);
      u_bus.inst_ready     = 1'b1;
      u_bus.redirect_valid = 1'b1;
      u_bus.redirect_pc    = 32'h40;
      @(posedge clk); #1;
      u_bus.redirect_valid = 1'b0;
      check("t5_valid_post", 32'(u_bus.inst_valid), 32'h0);
      check("t5_req_post",   32'(u_bus.imem_req),   32'h1);
      check("t5_addr_post",  u_bus.imem_addr,       32'h40);
      expect_pc(32'h40);
      expect_pc(32'h44);
      expect_pc(32'h48);
      drain("t5");

      // 6: PC wraps modulo 2^32
      do_reset();
      u_bus.inst_ready     = 1'b1;
      u_bus.redirect_valid = 1'b1;
      u_bus.redirect_pc    = 32'hFFFF_FFFC;
      expect_pc(32'hFFFF_FFFC);
      expect_pc(32'h0);
      expect_pc(32'h4);
      @(posedge clk); #1;
      u_bus.redirect_valid = 1'b0;
      check("t6_addr", u_bus.imem_addr, 32'hFFFF_FFFC);
      drain("t6");

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_inst_fetch_unit
`default_nettype wire
